// File: rtl/sled_rx_pkg.sv
// ============================================================================
// sled_rx_pkg : frame format and receiver state encoding for the LED serial link
// Rev 1.0
// ============================================================================
`default_nettype none

package sled_rx_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic LINE_IDLE      = 1'b0;
    localparam logic START_LVL      = 1'b1;
    localparam int   DEF_WIDTH      = 16;
    localparam int   DEF_BIT_CYCLES = 8;

endpackage

`default_nettype wire

// File: rtl/sled_sync.sv
// ============================================================================
// sled_sync : multi-stage input synchronizer with a "chain refilled" flag
// Rev 1.0
// ============================================================================
`default_nettype none

module sled_sync
    import sled_rx_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic primed
);

    logic [STAGES-1:0] chain;
    logic [STAGES-1:0] fill;

    // fill marks when every stage holds a post-reset sample of din
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{LINE_IDLE}};
            fill  <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            fill  <= {fill[STAGES-2:0], 1'b1};
        end
    end

    assign dout   = chain[STAGES-1];
    assign primed = fill[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/sled_rx.sv
// ============================================================================
// sled_rx : one-wire LED link receiver, start/data/stop framing, MSB first
// Rev 1.0
// ============================================================================
`default_nettype none

module sled_rx
    import sled_rx_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int BIT_CYCLES  = DEF_BIT_CYCLES,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(BIT_CYCLES);
    localparam int IDX_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);

    logic             sin_s;
    logic             primed;
    logic             sin_d;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] shreg;

    sled_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .din    (sin),
        .dout   (sin_s),
        .primed (primed)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            sin_d      <= 1'b1;
        end else begin
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            // Hold the edge register high until the synchronizer has flushed its
            // reset value, so a line that is already high never looks like an edge.
            sin_d      <= primed ? sin_s : sin_d;
            case (state)
                S_IDLE: begin
                    if (sin_s == START_LVL && sin_d == LINE_IDLE) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        idx <= '0;
                        state <= (sin_s == START_LVL) ? S_DATA : S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        shreg <= {shreg[WIDTH-2:0], sin_s};
                        cnt   <= '0;
                        idx   <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        if (sin_s == LINE_IDLE) begin
                            dout       <= shreg;
                            dout_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sled_rx.sv
// ============================================================================
// tb_sled_rx : directed + randomized frame bench for sled_rx
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sled_rx;

    localparam int W   = 16;
    localparam int B   = 8;
    localparam int S   = 2;
    // Edges counted from (and including) the first edge that samples the start bit.
    localparam int LAT = S + B / 2 + (W + 1) * B + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sin = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         frame_err;
    logic         busy;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int both_cnt = 0;
    logic [W-1:0] vq_d[$];
    int           vq_t[$];
    int           eq_t[$];

    sled_rx #(
        .WIDTH       (W),
        .BIT_CYCLES  (B),
        .SYNC_STAGES (S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dout_valid) begin
            vq_d.push_back(dout);
            vq_t.push_back(cyc);
        end
        if (frame_err) eq_t.push_back(cyc);
        if (dout_valid && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        vq_d.delete();
        vq_t.delete();
        eq_t.delete();
    endtask

    // Called at a negedge; leaves the line at the stop level.
    task automatic send_frame(input logic [W-1:0] d, input logic stop, output int t0);
        t0  = cyc;
        sin = 1'b1;
        repeat (B) @(negedge clk);
        for (int i = W - 1; i >= 0; i--) begin
            sin = d[i];
            repeat (B) @(negedge clk);
        end
        sin = stop;
        repeat (B) @(negedge clk);
    endtask

    task automatic idle(input int n);
        sin = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t0, t1, bcnt, nerr_exp, nchk;
        logic [W-1:0] d, last_good;
        logic bad;
        int g;
        logic [W-1:0] expw[$];
        int           exps[$];

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        idle(2 * B);

        // 1: single clean frame, latency
        clear_q();
        send_frame(16'hA5C3, 1'b0, t0);
        idle(4);
        check("t1_nvalid", vq_d.size(), 1);
        check("t1_nerr", eq_t.size(), 0);
        if (vq_d.size() > 0) begin
            check("t1_data", vq_d[0], 16'hA5C3);
            check("t1_latency", vq_t[0] - t0, LAT);
        end
        check("t1_dout", dout, 16'hA5C3);

        // 2: back-to-back frames
        idle(2 * B);
        clear_q();
        send_frame(16'hFFFF, 1'b0, t0);
        send_frame(16'h0001, 1'b0, t1);
        idle(4);
        check("t2_nvalid", vq_d.size(), 2);
        if (vq_d.size() == 2) begin
            check("t2_data0", vq_d[0], 16'hFFFF);
            check("t2_data1", vq_d[1], 16'h0001);
            check("t2_lat1", vq_t[1] - t1, LAT);
        end

        // 3: bad stop bit, line left high, then a clean frame
        idle(2 * B);
        clear_q();
        send_frame(16'h1234, 1'b1, t0);
        repeat (3 * B) @(negedge clk);
        check("t3_nerr", eq_t.size(), 1);
        check("t3_nvalid", vq_d.size(), 0);
        check("t3_dout_kept", dout, 16'h0001);
        check("t3_idle_busy", busy, 0);
        idle(2 * B);
        send_frame(16'h00FF, 1'b0, t0);
        idle(4);
        check("t3_next", dout, 16'h00FF);
        check("t3_nvalid2", vq_d.size(), 1);

        // 4: 2-cycle glitch
        idle(2 * B);
        clear_q();
        sin = 1'b1;
        repeat (2) @(negedge clk);
        sin = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 4 * B; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        check("t4_busy_seen", bcnt > 0, 1);
        check("t4_busy_short", bcnt <= B / 2 + 1, 1);
        check("t4_events", vq_d.size() + eq_t.size(), 0);

        // 5: reset in the middle of a data bit
        idle(2 * B);
        clear_q();
        sin = 1'b1;
        repeat (B) @(negedge clk);
        d = 16'hBEEF;
        for (int i = W - 1; i >= W - 9; i--) begin
            sin = d[i];
            repeat (B) @(negedge clk);
        end
        repeat (B / 2) @(negedge clk);
        rst = 1'b1;
        sin = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("t5_dout0", dout, 0);
        check("t5_busy0", busy, 0);
        idle((W + 4) * B);
        check("t5_events", vq_d.size() + eq_t.size(), 0);
        send_frame(16'h8001, 1'b0, t0);
        idle(4);
        check("t5_next", dout, 16'h8001);

        // 6: line high across reset release
        idle(2 * B);
        clear_q();
        sin = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 20 * B; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        check("t6_no_start", bcnt, 0);
        check("t6_events", vq_d.size() + eq_t.size(), 0);
        idle(2 * B);
        send_frame(16'h5A5A, 1'b0, t0);
        idle(4);
        check("t6_next", dout, 16'h5A5A);
        last_good = 16'h5A5A;

        // Randomized frame stream against a frame-level model
        idle(2 * B);
        clear_q();
        nerr_exp = 0;
        for (int k = 0; k < 12; k++) begin
            d   = W'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            send_frame(d, bad, t0);
            if (bad) begin
                nerr_exp++;
                g = $urandom_range(1, 3);
            end else begin
                expw.push_back(d);
                exps.push_back(t0);
                last_good = d;
                g = $urandom_range(0, 2);
            end
            if (g > 0) idle(g * B + $urandom_range(0, 3));
        end
        idle(B);
        check("rnd_nvalid", vq_d.size(), expw.size());
        check("rnd_nerr", eq_t.size(), nerr_exp);
        nchk = (vq_d.size() < expw.size()) ? vq_d.size() : expw.size();
        for (int i = 0; i < nchk; i++) begin
            check($sformatf("rnd_data%0d", i), vq_d[i], expw[i]);
            check($sformatf("rnd_lat%0d", i), vq_t[i] - exps[i], LAT);
        end
        check("rnd_dout", dout, last_good);
        check("excl_pulses", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
